mdu_iter: RTL and testbench

- Iterative multiply/divide unit in the execute stage, beside the ALU, fed by the same srca/srcb operands.
- Implements mult, multu, div and divu into architectural HI/LO registers. Also supports mthi/mtlo.
- HI and LO are read combinationally by the writeback mux for mfhi/mflo.
- busy stalls the controller while an operation is in flight.

---
 rtl/mdu_iter.sv | 145 ++++++++++++++
 tb/tb_mdu_iter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by a one-cycle sign fix-up into HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

    state_t             r_state, w_state_next;
    logic [CNTW-1:0]    r_cnt;
    logic [1:0]         r_op;
    logic               r_sign_a, r_sign_b;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_acc_hi, r_acc_lo;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done;

    logic               w_signed, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh, w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic               w_neg_res;

    assign w_signed = ~mdop[0];
    assign w_neg_a  = w_signed & a[WIDTH-1];
    assign w_neg_b  = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -a : a;
    assign w_mag_b  = w_neg_b ? -b : b;

    // Multiply: r_acc_lo holds the multiplier and shifts out as product bits shift in.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: r_acc_hi is the partial remainder, r_acc_lo shifts dividend out / quotient in.
    assign w_div_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ok   = (w_div_sh >= {1'b0, r_opnd});
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};

    assign w_neg_res  = r_sign_a ^ r_sign_b;
    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = w_neg_res ? -w_prod : w_prod;
    assign w_quot     = w_neg_res ? -r_acc_lo : r_acc_lo;
    assign w_rem      = r_sign_a ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_state_next = S_SIGN;
            S_SIGN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_raw  <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= mdop;
                        r_a_raw  <= a;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_cnt    <= CNTW'(WIDTH - 1);
                        r_acc_hi <= '0;
                        if (mdop[1]) begin
                            r_acc_lo <= w_mag_a;
                            r_opnd   <= w_mag_b;
                        end else begin
                            r_acc_lo <= w_mag_b;
                            r_opnd   <= w_mag_a;
                        end
                    end else begin
                        if (mthi) r_hi <= a;
                        if (mtlo) r_lo <= a;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNTW'(1);
                    if (r_op[1]) begin
                        r_acc_hi <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                end
                S_SIGN: begin
                    r_done <= 1'b1;
                    if (!r_op[1]) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_opnd == '0) begin
                        // Divide by zero bypasses the sign fix entirely.
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mdop;
    logic [31:0] a, b;
    logic        mthi, mtlo;
    logic [31:0] hi, lo;
    logic        busy, done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu_iter #(.WIDTH(32), .CNTW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: MIPS semantics computed with plain integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] av, bv,
                         output logic [31:0] eh, el);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = int'(av);
        sb = int'(bv);
        eh = '0;
        el = '0;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'b01: begin
                up = {32'b0, av} * {32'b0, bv};
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (bv == 32'd0) begin
                    eh = av;
                    el = 32'hFFFF_FFFF;
                end else if (op == 2'b10 && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    eh = 32'd0;
                    el = 32'h8000_0000;
                end else if (op == 2'b10) begin
                    el = sa / sb;
                    eh = sa % sb;
                end else begin
                    el = av / bv;
                    eh = av % bv;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] av, bv);
        start = 1'b1;
        mdop  = op;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        mdop  = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input string name, input logic [31:0] eh, el, input int already);
        int n;
        n = already;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_vec++;
        if (n !== 33) begin
            n_err++;
            $display("FAIL %s latency: got %0d busy cycles, expected 33", name, n);
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s done: got %b, expected 1", name, done);
        end
        n_vec++;
        if ({hi, lo} !== {eh, el}) begin
            n_err++;
            $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, eh, el);
        end
        $display("op %-12s hi=%h lo=%h latency=%0d", name, hi, lo, n);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] av, bv);
        logic [31:0] eh, el;
        model(op, av, bv, eh, el);
        issue(op, av, bv);
        wait_done(name, eh, el, 0);
    endtask

    task automatic write_hilo(input logic wh, wl, input logic [31:0] v);
        mthi = wh;
        mtlo = wl;
        a    = v;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        n_vec++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_err++;
            $display("FAIL mthi/mtlo: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        $display("mt  hi=%b lo=%b data=%h -> hi=%h lo=%h", wh, wl, v, hi, lo);
    endtask

    task automatic test_reset();
        n_vec++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            n_err++;
            $display("FAIL reset state: got hi=%h lo=%h busy=%b done=%b, expected all zero",
                     hi, lo, busy, done);
        end
        $display("reset hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_mult();
        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done width: got %b one cycle later, expected 0", done);
        end
        run_op("multu ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu /0", 2'b11, 32'h1234_5678, 32'd0);
        run_op("div /0", 2'b10, 32'h1234_5678, 32'd0);
        run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_mt();
        write_hilo(1'b1, 1'b0, 32'h0BAD_F00D);
        write_hilo(1'b0, 1'b1, 32'h1357_9BDF);
        write_hilo(1'b1, 1'b1, 32'h5A5A_A5A5);
        // mthi/mtlo alongside start must be ignored.
        mthi = 1'b1;
        mtlo = 1'b1;
        issue(2'b01, 32'd11, 32'd13);
        mthi = 1'b0;
        mtlo = 1'b0;
        n_vec++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_err++;
            $display("FAIL mt with start: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        wait_done("multu 11*13", 32'd0, 32'd143, 0);
    endtask

    task automatic test_busy_ignore();
        issue(2'b00, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        start = 1'b1;
        mdop  = 2'b11;
        a     = 32'd9;
        b     = 32'd3;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        a     = ~a;
        n_vec++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_err++;
            $display("FAIL busy mthi: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        wait_done("mult 5*6 int", 32'd0, 32'd30, 10);
        write_hilo(1'b1, 1'b0, 32'h0000_ABCD);
    endtask

    task automatic test_reset_mid();
        int ndone;
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        n_vec++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            n_err++;
            $display("FAIL async reset: got hi=%h lo=%h busy=%b done=%b, expected all zero",
                     hi, lo, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset abort: got %0d busy/done cycles after reset, expected 0", ndone);
        end
        $display("reset mid-op hi=%h lo=%h", hi, lo);
        run_op("multu 2*3", 2'b01, 32'd2, 32'd3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh, el;
        run_op("b2b first", 2'b10, 32'hFFFF_FF00, 32'd3);
        model(2'b11, 32'hCAFE_F00D, 32'd1000, eh, el);
        issue(2'b11, 32'hCAFE_F00D, 32'd1000);
        n_vec++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        wait_done("b2b second", eh, el, 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
                2: bv = 32'($urandom_range(1, 15));
                3: bv = -32'($urandom_range(1, 15));
                4: write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, op), op, av, bv);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mdop  = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_mult();
        test_div();
        test_mt();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
